prefetch_buffer: RTL and testbench
==================================

// Module: prefetch_buffer
// PURPOSE
//   Instruction prefetcher between instruction memory and the IF/ID boundary.
//   Issues sequential word fetches over a req/gnt/rvalid interface and queues {pc, instr, err} in an in-order FIFO.
//   Presents the FIFO head to the decode side with a valid/ready handshake.
//   Redirects (jump, branch, trap, mret) arrive as flush_i + flush_addr_i, computed by the existing PC controller.
// PARAMETERS
//   DEPTH  4  FIFO entries and max in-flight fetches; power of two, >= 2
// PORTS
//   clk_i           in   1   clock, all state on rising edge
//   rst_i           in   1   synchronous, active-high reset
//   boot_addr_i     in   30  word address of first fetch after reset
//   flush_i         in   1   redirect: drop queued/in-flight instrs, restart at flush_addr_i
//   flush_addr_i    in   32  redirect target; bits [1:0] ignored (treated as 0)
//   instr_req_o     out  1   fetch request
//   instr_addr_o    out  32  fetch word address, bits [1:0] = 0
//   instr_gnt_i     in   1   request accepted this cycle
//   instr_rvalid_i  in   1   response valid; responses return in request order
//   instr_rdata_i   in   32  response instruction word
//   instr_err_i     in   1   response bus error, qualified by rvalid
//   valid_o         out  1   head entry available
//   ready_i         in   1   consumer takes head when valid_o && ready_i
//   pc_o            out  32  head entry PC
//   instr_o         out  32  head entry instruction
//   err_o           out  1   head entry fetch error
//   busy_o          out  1   outstanding != 0
// BEHAVIOUR
//   Reset: fetch_addr = {boot_addr_i,2'b0}, resp_pc = same, count = 0, outstanding = 0, discard = 0.
//     Outputs: req_o = 0, valid_o = 0, pc_o/instr_o/err_o = 0, busy_o = 0.
//     Reset during traffic: every in-flight response after reset is ignored.
//     The memory side is also reset, so none are counted.
//   Credit rule: instr_req_o = !flush_i && !rst_i && (count + outstanding < DEPTH).
//     No pop lookahead; overflow is impossible by construction.
//   Memory side tolerates retraction: req/addr may drop or change before gnt; no hold-until-gnt rule.
//   instr_addr_o = fetch_addr (registered). On req&&gnt: fetch_addr += 4, outstanding += 1.
//   On rvalid: outstanding -= 1.
//     If discard != 0: discard -= 1, response dropped.
//     Else: push {resp_pc, rdata, err}, resp_pc += 4.
//   gnt and rvalid in the same cycle leave outstanding unchanged.
//   Output: valid_o = (count != 0) && !flush_i. Fields come from the FIFO head. Latency: rvalid -> valid_o is 1 cycle.
//   Pop when valid_o && ready_i. Push+pop in the same cycle: count unchanged, order preserved. pc_o/instr_o stable while valid_o && !ready_i.
//   Flush cycle:
//     - no pop, no push, req_o = 0.
//     - Next cycle: count = 0, fetch_addr = resp_pc = {flush_addr_i[31:2],2'b0}.
//     - discard = outstanding_next, i.e. the in-flight count including this cycle's gnt/rvalid adjustments.
//     - Flush wins over every simultaneous event.
//     - Back-to-back flushes: the latest target wins, and discard accumulates correctly.
//   Error: err is stored per entry. Fetching continues; the trap decision belongs downstream.
//   Wrap-around: fetch_addr and resp_pc wrap modulo 2^32. FIFO pointers wrap modulo DEPTH.
//   Counters: count and outstanding use $clog2(DEPTH+1) bits; the invariant count + outstanding <= DEPTH is asserted.
//   Assertions: rvalid with outstanding == 0 is an error; push with count == DEPTH is an error.
// STRUCTURE
//   core_pkg: typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic err;} fetch_entry_t.
//   Sub-module fetch_fifo #(DEPTH, fetch_entry_t):
//     - sync FIFO with push/pop/flush, count_o, and a head output.
//     - flush clears pointers; registered storage; no output register.
//   Top level holds fetch_addr, resp_pc, outstanding, discard, and the credit/request logic.
// TESTING
//   1. boot_addr_i=30'h0000_0040, gnt/rvalid every cycle, ready_i=1 -> pc_o sequence 0x100,0x104,0x108; a sustained pop every cycle after a 2-cycle fill.
//   2. ready_i=0, gnt always, rvalid next cycle -> exactly 4 requests issued; req_o stays 0 with count=4. Raise ready_i -> one new request per pop.
//   3. 3 fetches in flight, flush_i with flush_addr_i=0x2003 -> all 3 responses dropped. First valid_o has pc_o=0x2000 and instr = the 4th response.
//   4. Flush in the same cycle as gnt+rvalid and a pending pop -> no pop, no push, discard = new outstanding, valid_o=0 that cycle.
//   5. instr_err_i=1 on the 2nd response -> err_o=1 only on that entry. The following entries are normal, with pc advancing by 4.
//   6. rst_i asserted with 2 in flight and 2 queued -> next cycle valid_o=0, busy_o=0, instr_addr_o={boot_addr_i,2'b0}, req_o resumes.

Source files
------------

// File: rtl/prefetch_buffer_pkg.sv
// Shared types for the instruction prefetch buffer: the queued fetch entry
// and a word-alignment helper for redirect targets.
package prefetch_buffer_pkg;

   localparam logic [31:0] WORD_BYTES = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/prefetch_buffer_fetch_fifo.sv
// In-order synchronous FIFO holding fetched entries; head is read straight
// from storage (no output register), flush drops everything in one cycle.
module fetch_fifo
   import prefetch_buffer_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  T                           data_i,
   output T                           head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   T              mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;

   // Storage is cleared on reset so the head fields read as zero afterwards.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_i) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_i) rd_ptr <= rd_ptr + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_o  = mem[rd_ptr];
   assign count_o = count;

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && count == CW'(DEPTH)));

endmodule

// File: rtl/prefetch_buffer.sv
// Sequential instruction prefetcher: credit-limited word fetches, in-order
// response queueing, and redirect handling that discards stale in-flight data.
module prefetch_buffer
   import prefetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [29:0] boot_addr_i,
   input  logic        flush_i,
   input  logic [31:0] flush_addr_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]   fetch_addr;
   logic [31:0]   resp_pc;
   logic [31:0]   flush_target;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] outstanding_next;
   logic [CW-1:0] discard;
   logic [CW-1:0] count;
   logic [CW:0]   in_use;
   logic          fire;
   logic          push;
   logic          pop;
   fetch_entry_t  entry;
   fetch_entry_t  head;

   assign flush_target     = word_align(flush_addr_i);
   assign in_use           = {1'b0, count} + {1'b0, outstanding};
   // Credits cover both queued and in-flight words, so a response always has room.
   assign instr_req_o      = !flush_i && !rst_i && (in_use < (CW+1)'(DEPTH));
   assign instr_addr_o     = fetch_addr;
   assign fire             = instr_req_o && instr_gnt_i;
   assign outstanding_next = outstanding + CW'(fire) - CW'(instr_rvalid_i);

   assign push    = instr_rvalid_i && (discard == '0) && !flush_i;
   assign valid_o = (count != '0) && !flush_i;
   assign pop     = valid_o && ready_i;
   assign entry   = '{pc: resp_pc, instr: instr_rdata_i, err: instr_err_i};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_addr  <= {boot_addr_i, 2'b00};
         resp_pc     <= {boot_addr_i, 2'b00};
         outstanding <= '0;
         discard     <= '0;
      end else if (flush_i) begin
         // Every word still in flight belongs to the old stream.
         fetch_addr  <= flush_target;
         resp_pc     <= flush_target;
         outstanding <= outstanding_next;
         discard     <= outstanding_next;
      end else begin
         outstanding <= outstanding_next;
         if (fire) fetch_addr <= fetch_addr + WORD_BYTES;
         if (instr_rvalid_i) begin
            if (discard != '0) discard <= discard - CW'(1);
            else               resp_pc <= resp_pc + WORD_BYTES;
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush_i),
      .data_i  (entry),
      .head_o  (head),
      .count_o (count)
   );

   assign pc_o    = head.pc;
   assign instr_o = head.instr;
   assign err_o   = head.err;
   assign busy_o  = outstanding != '0;

   a_rvalid_expected: assert property (@(posedge clk_i) disable iff (rst_i)
      !(instr_rvalid_i && outstanding == '0));
   a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      in_use <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_prefetch_buffer.sv
// Bench for prefetch_buffer: directed vector table, hand-written corner
// sequences, and a randomized run against a stream-level reference model.
module tb_prefetch_buffer;

   localparam int DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [29:0] boot_addr_i = 30'h40;
   logic        flush_i = 1'b0;
   logic [31:0] flush_addr_i = '0;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i = 1'b0;
   logic        instr_rvalid_i = 1'b0;
   logic [31:0] instr_rdata_i = '0;
   logic        instr_err_i = 1'b0;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic [31:0] pc_o;
   logic [31:0] instr_o;
   logic        err_o;
   logic        busy_o;

   prefetch_buffer #(.DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .boot_addr_i(boot_addr_i),
      .flush_i(flush_i), .flush_addr_i(flush_addr_i),
      .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
      .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
      .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o),
      .instr_o(instr_o), .err_o(err_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: granted requests tagged with a redirect epoch, and the
   // stream of entries the decoder should see.
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          epoch;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } ent_t;

   typedef struct {
      bit          rst, flush;
      logic [31:0] faddr;
      bit          gnt, rv, rdy;
      bit          exp_req;
      logic [31:0] exp_addr;
      bit          exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   req_t        pend[$];
   ent_t        exp_q[$];
   int          epoch = 0;
   logic [31:0] next_addr = '0;
   bit          rand_data = 1'b0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0b want %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs; a response is only offered if one is owed.
   task automatic drive(input bit rst, input bit flush, input logic [31:0] fa,
                        input bit gnt, input bit rv, input bit rdy, input bit err);
      bit rv_now;
      @(negedge clk_i);
      rv_now         = rv && (pend.size() != 0);
      rst_i          = rst;
      flush_i        = flush;
      flush_addr_i   = fa;
      instr_gnt_i    = gnt;
      ready_i        = rdy;
      instr_rvalid_i = rv_now;
      instr_rdata_i  = rv_now ? pend[0].data : 32'h0;
      instr_err_i    = rv_now && err;
      #1;
   endtask

   // Compare against the model, then commit this cycle's events to it.
   task automatic advance();
      bit   er, ev;
      req_t r;
      if (rst_i) begin
         chk1("rst_req", instr_req_o, 1'b0);
         pend.delete();
         exp_q.delete();
         epoch++;
         next_addr = {boot_addr_i, 2'b00};
      end else begin
         er = !flush_i && (exp_q.size() + pend.size() < DEPTH);
         ev = (exp_q.size() != 0) && !flush_i;
         chk1("m_req", instr_req_o, er);
         if (er) chk("m_addr", instr_addr_o, next_addr);
         chk1("m_valid", valid_o, ev);
         chk1("m_busy", busy_o, pend.size() != 0);
         if (ev) begin
            chk("m_pc", pc_o, exp_q[0].pc);
            chk("m_instr", instr_o, exp_q[0].instr);
            chk1("m_err", err_o, exp_q[0].err);
         end
         if (ev && ready_i) void'(exp_q.pop_front());
         if (instr_rvalid_i) begin
            r = pend.pop_front();
            if (!flush_i && r.epoch == epoch)
               exp_q.push_back('{pc: r.addr, instr: instr_rdata_i, err: instr_err_i});
         end
         if (flush_i) begin
            exp_q.delete();
            epoch++;
            next_addr = {flush_addr_i[31:2], 2'b00};
         end else if (er && instr_gnt_i) begin
            pend.push_back('{addr: next_addr, data: rand_data ? $urandom : ~next_addr,
                             epoch: epoch});
            next_addr = next_addr + 32'd4;
         end
      end
      @(posedge clk_i);
   endtask

   task automatic cyc(input bit rst, input bit flush, input logic [31:0] fa,
                      input bit gnt, input bit rv, input bit rdy, input bit err);
      drive(rst, flush, fa, gnt, rv, rdy, err);
      advance();
   endtask

   function automatic vec_t v(input bit rst, input bit gnt, input bit rv, input bit rdy,
                              input bit er, input logic [31:0] ea,
                              input bit ev, input logic [31:0] ep);
      vec_t x;
      x = '{rst: rst, flush: 1'b0, faddr: 32'h0, gnt: gnt, rv: rv, rdy: rdy,
            exp_req: er, exp_addr: ea, exp_valid: ev, exp_pc: ep};
      return x;
   endfunction

   initial begin
      vec_t tbl[$];
      bit   f;
      logic [31:0] fa;

      // Sustained stream from boot 0x100, then credit exhaustion with ready low.
      tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,   0, 32'h0));
      tbl.push_back(v(0, 1, 1, 1, 1, 32'h100, 0, 32'h0));
      tbl.push_back(v(0, 1, 1, 1, 1, 32'h104, 0, 32'h0));
      tbl.push_back(v(0, 1, 1, 1, 1, 32'h108, 1, 32'h100));
      tbl.push_back(v(0, 1, 1, 1, 1, 32'h10C, 1, 32'h104));
      tbl.push_back(v(0, 1, 1, 1, 1, 32'h110, 1, 32'h108));
      tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,   0, 32'h0));
      tbl.push_back(v(0, 1, 0, 0, 1, 32'h100, 0, 32'h0));
      tbl.push_back(v(0, 1, 1, 0, 1, 32'h104, 0, 32'h0));
      tbl.push_back(v(0, 1, 1, 0, 1, 32'h108, 1, 32'h100));
      tbl.push_back(v(0, 1, 1, 0, 1, 32'h10C, 1, 32'h100));
      tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,   1, 32'h100));
      tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,   1, 32'h100));
      tbl.push_back(v(0, 1, 0, 1, 0, 32'h0,   1, 32'h100));
      tbl.push_back(v(0, 1, 0, 1, 1, 32'h110, 1, 32'h104));

      // Reset state.
      cyc(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk1("rst_valid", valid_o, 1'b0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_instr", instr_o, 32'h0);
      chk1("rst_err", err_o, 1'b0);
      chk1("rst_busy", busy_o, 1'b0);
      chk("rst_addr", instr_addr_o, 32'h100);
      advance();

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].flush, tbl[i].faddr, tbl[i].gnt, tbl[i].rv, tbl[i].rdy, 0);
         chk1($sformatf("vec%0d_req", i), instr_req_o, tbl[i].exp_req);
         if (tbl[i].exp_req) chk($sformatf("vec%0d_addr", i), instr_addr_o, tbl[i].exp_addr);
         if (!tbl[i].rst) chk1($sformatf("vec%0d_valid", i), valid_o, tbl[i].exp_valid);
         if (tbl[i].exp_valid) chk($sformatf("vec%0d_pc", i), pc_o, tbl[i].exp_pc);
         advance();
      end

      // Redirect with three words in flight; unaligned target.
      cyc(1, 0, 0, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 1, 0, 1, 0);
      drive(0, 1, 32'h2003, 1, 0, 1, 0);
      chk1("t3_flush_req", instr_req_o, 1'b0);
      advance();
      drive(0, 0, 0, 1, 1, 1, 0);
      chk("t3_target", instr_addr_o, 32'h2000);
      chk1("t3_busy", busy_o, 1'b1);
      advance();
      repeat (3) begin
         drive(0, 0, 0, 1, 1, 1, 0);
         chk1("t3_stale_valid", valid_o, 1'b0);
         advance();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      chk1("t3_valid", valid_o, 1'b1);
      chk("t3_pc", pc_o, 32'h2000);
      chk("t3_instr", instr_o, ~32'h2000);
      advance();

      // Redirect colliding with grant, response and a pending pop.
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, 0);
      drive(0, 1, 32'h3000, 1, 1, 1, 0);
      chk1("t4_flush_valid", valid_o, 1'b0);
      chk1("t4_flush_req", instr_req_o, 1'b0);
      advance();
      drive(0, 0, 0, 1, 1, 0, 0);
      chk1("t4_busy", busy_o, 1'b1);
      chk("t4_addr", instr_addr_o, 32'h3000);
      chk1("t4_valid0", valid_o, 1'b0);
      advance();
      drive(0, 0, 0, 0, 1, 0, 0);
      chk1("t4_valid1", valid_o, 1'b0);
      advance();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk1("t4_valid2", valid_o, 1'b1);
      chk("t4_pc", pc_o, 32'h3000);
      advance();

      // Bus error on the second response only.
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 0, 1, 1, 1, i == 2);
         if (i >= 2) begin
            chk("t5_pc", pc_o, 32'h100 + 32'(4 * (i - 2)));
            chk1("t5_err", err_o, i == 3);
         end
         advance();
      end

      // Reset mid-traffic with a new boot address.
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      boot_addr_i = 30'h1000;
      cyc(1, 0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk1("t6_valid", valid_o, 1'b0);
      chk1("t6_busy", busy_o, 1'b0);
      chk("t6_addr", instr_addr_o, 32'h4000);
      chk1("t6_req", instr_req_o, 1'b1);
      advance();

      // Randomized traffic, including redirects near the top of the address space.
      rand_data = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         f  = ($urandom_range(0, 15) == 0);
         fa = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
         if ($urandom_range(0, 199) == 0) boot_addr_i = 30'($urandom);
         drive($urandom_range(0, 199) == 0, f, fa, $urandom_range(0, 9) < 7,
               $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
               $urandom_range(0, 9) == 0);
         advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
